// File: rtl/pingpong_bram_ctrl_pkg.sv
// rtl/pingpong_bram_ctrl_pkg.sv - shared types and defaults for the ping-pong BRAM controller
package pingpong_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        SWAP = 2'd2
    } pp_state_e;
endpackage

// File: rtl/pingpong_bram_ctrl_if.sv
// rtl/pingpong_bram_ctrl_if.sv - single-port BRAM bank port bundle
interface pingpong_bram_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output en, output we, output addr, output din, input dout);
    modport slave  (input en, input we, input addr, input din, output dout);
endinterface

// File: rtl/pingpong_bram_ctrl_bank_port.sv
// rtl/pingpong_bram_ctrl_bank_port.sv - registered write/read mux for one bank, chosen by role
module pp_bank_port #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_wr_bank,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din
);
    // addr/din deliberately hold when idle so an unused bank sees no toggling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en   <= 1'b0;
            we   <= 1'b0;
            addr <= '0;
            din  <= '0;
        end else begin
            en <= 1'b0;
            we <= 1'b0;
            if (is_wr_bank) begin
                if (wr_req) begin
                    en   <= 1'b1;
                    we   <= 1'b1;
                    addr <= wr_addr;
                    din  <= wr_data;
                end
            end else if (rd_req) begin
                en   <= 1'b1;
                addr <= rd_addr;
            end
        end
    end
endmodule

// File: rtl/pingpong_bram_ctrl.sv
// rtl/pingpong_bram_ctrl.sv - ping-pong scheduler: fills one bank while the other is read out
module pingpong_bram_ctrl
    import pingpong_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  w_tick,
    input  logic [DATA_W-1:0]     w_data,
    input  logic                  r_tick,
    input  logic                  clr_flags,
    pingpong_bram_ctrl_if.master  bank0,
    pingpong_bram_ctrl_if.master  bank1,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  wr_bank,
    output logic                  swap,
    output logic [7:0]            frame_cnt,
    output logic                  overrun,
    output logic                  underrun
);
    localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W+1)'(2 ** ADDR_W);

    pp_state_e         state, state_nxt;
    logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic              wr_acc, rd_acc, w_drop, r_drop, swap_nxt;
    logic              rd_p1, rd_sel_p1, rd_sel;

    // Full/done are judged on the post-update pointers so the swap follows the last access directly
    always_comb begin
        state_nxt  = state;
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        w_drop     = 1'b0;
        r_drop     = 1'b0;
        swap_nxt   = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        case (state)
            FILL, RUN: begin
                wr_acc = w_tick && (wr_ptr != FULL_PTR);
                rd_acc = r_tick && (state == RUN) && (rd_ptr != FULL_PTR);
                w_drop = w_tick && !wr_acc;
                r_drop = r_tick && !rd_acc;
                if (wr_acc) wr_ptr_nxt = wr_ptr + 1'b1;
                if (rd_acc) rd_ptr_nxt = rd_ptr + 1'b1;
                if (wr_ptr_nxt == FULL_PTR && (state == FILL || rd_ptr_nxt == FULL_PTR)) begin
                    state_nxt  = SWAP;
                    swap_nxt   = 1'b1;
                    wr_ptr_nxt = '0;
                    rd_ptr_nxt = '0;
                end
            end
            SWAP: begin
                w_drop    = w_tick;
                r_drop    = r_tick;
                state_nxt = RUN;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_bank   <= 1'b0;
            swap      <= 1'b0;
            frame_cnt <= 8'd0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            rd_p1     <= 1'b0;
            rd_sel_p1 <= 1'b0;
            rd_valid  <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            wr_bank   <= wr_bank ^ swap_nxt;
            swap      <= swap_nxt;
            frame_cnt <= frame_cnt + 8'(swap_nxt);
            overrun   <= w_drop | (overrun & ~clr_flags);
            underrun  <= r_drop | (underrun & ~clr_flags);
            rd_p1     <= rd_acc;
            rd_sel_p1 <= ~wr_bank;
            rd_valid  <= rd_p1;
            rd_sel    <= rd_sel_p1;
        end
    end

    assign rd_data = rd_sel ? bank1.dout : bank0.dout;

    pp_bank_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .is_wr_bank (~wr_bank),
        .wr_req     (wr_acc),
        .wr_addr    (wr_ptr[ADDR_W-1:0]),
        .wr_data    (w_data),
        .rd_req     (rd_acc),
        .rd_addr    (rd_ptr[ADDR_W-1:0]),
        .en         (bank0.en),
        .we         (bank0.we),
        .addr       (bank0.addr),
        .din        (bank0.din)
    );

    pp_bank_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .is_wr_bank (wr_bank),
        .wr_req     (wr_acc),
        .wr_addr    (wr_ptr[ADDR_W-1:0]),
        .wr_data    (w_data),
        .rd_req     (rd_acc),
        .rd_addr    (rd_ptr[ADDR_W-1:0]),
        .en         (bank1.en),
        .we         (bank1.we),
        .addr       (bank1.addr),
        .din        (bank1.din)
    );
endmodule

// File: tb/tb_pingpong_bram_ctrl.sv
// tb/tb_pingpong_bram_ctrl.sv - scoreboard bench for pingpong_bram_ctrl with frame-level reference model
module tb_pingpong_bram_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          sys_clk   = 1'b0;
    logic          rst_n     = 1'b1;
    logic          w_tick    = 1'b0;
    logic          r_tick    = 1'b0;
    logic          clr_flags = 1'b0;
    logic [DW-1:0] w_data    = '0;
    logic [DW-1:0] rd_data;
    logic [7:0]    frame_cnt;
    logic          rd_valid, wr_bank, swap, overrun, underrun;

    pingpong_bram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bank0 ();
    pingpong_bram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bank1 ();

    always #5 sys_clk = ~sys_clk;

    pingpong_bram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .w_tick    (w_tick),
        .w_data    (w_data),
        .r_tick    (r_tick),
        .clr_flags (clr_flags),
        .bank0     (bank0),
        .bank1     (bank1),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_bank   (wr_bank),
        .swap      (swap),
        .frame_cnt (frame_cnt),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    always @(posedge sys_clk) begin
        if (bank0.en === 1'b1) begin
            if (bank0.we) mem0[bank0.addr] <= bank0.din;
            else          bank0.dout <= mem0[bank0.addr];
        end
        if (bank1.en === 1'b1) begin
            if (bank1.we) mem1[bank1.addr] <= bank1.din;
            else          bank1.dout <= mem1[bank1.addr];
        end
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct { int cyc; int bank; int addr; int data; } acc_t;
    typedef struct { int cyc; int data; } rd_t;
    typedef struct { int cyc; int fc; int wb; } sw_t;
    acc_t wq[$];
    acc_t raq[$];
    rd_t  rdq[$];
    sw_t  swq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame contents plus word counts per frame
    int            m_wcnt, m_rcnt, m_wbank, m_fc;
    bit            m_fill, m_swapcyc, m_ov, m_un;
    logic [DW-1:0] frame [2][DEPTH];

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_wbank = 0; m_fc = 0;
        m_fill = 1; m_swapcyc = 0; m_ov = 0; m_un = 0;
    endtask

    task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        bit wd = 0;
        bit rdp = 0;
        if (m_swapcyc) begin
            wd = w;
            rdp = r;
            m_swapcyc = 0;
        end else begin
            if (w) begin
                if (m_wcnt < DEPTH) begin
                    frame[m_wbank][m_wcnt] = d;
                    wq.push_back(acc_t'{cyc, m_wbank, m_wcnt, int'(d)});
                    m_wcnt++;
                end else wd = 1;
            end
            if (r) begin
                if (!m_fill && m_rcnt < DEPTH) begin
                    raq.push_back(acc_t'{cyc, 1 - m_wbank, m_rcnt, 0});
                    rdq.push_back(rd_t'{cyc, int'(frame[1 - m_wbank][m_rcnt])});
                    m_rcnt++;
                end else rdp = 1;
            end
            if (m_wcnt == DEPTH && (m_fill || m_rcnt == DEPTH)) begin
                m_wbank = 1 - m_wbank;
                m_wcnt = 0;
                m_rcnt = 0;
                m_fill = 0;
                m_fc++;
                m_swapcyc = 1;
                swq.push_back(sw_t'{cyc, m_fc % 256, m_wbank});
            end
        end
        m_ov = wd  || (m_ov && !c);
        m_un = rdp || (m_un && !c);
    endtask

    task automatic cycle(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
        @(negedge sys_clk);
        w_tick = w; r_tick = r; clr_flags = c; w_data = d;
        step(w, r, c, d);
        @(posedge sys_clk);
        #1;
        chk("overrun",   32'(overrun),   32'(m_ov));
        chk("underrun",  32'(underrun),  32'(m_un));
        chk("wr_bank",   32'(wr_bank),   32'(m_wbank));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fc % 256));
    endtask

    task automatic do_reset();
        w_tick = 0; r_tick = 0; clr_flags = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_status", {26'h0, rd_valid, wr_bank, swap, overrun, underrun, 1'b0}, 32'h0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("rst_bank0", {18'h0, bank0.en, bank0.we, bank0.addr, bank0.din}, 32'h0);
        chk("rst_bank1", {18'h0, bank1.en, bank1.we, bank1.addr, bank1.din}, 32'h0);
        wq.delete(); raq.delete(); rdq.delete(); swq.delete();
        model_reset();
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic mon_bank(input int b, input logic en, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] din);
        acc_t e;
        if (en === 1'b1) begin
            if (we) begin
                chk("wr_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    chk("bank_write", {8'(cyc - e.cyc), 8'(b), 4'h0, addr, din},
                                      {8'd1, 8'(e.bank), 4'h0, 4'(e.addr), 8'(e.data)});
                end
            end else begin
                chk("rd_access_expected", 32'(raq.size() != 0), 32'd1);
                if (raq.size() != 0) begin
                    e = raq.pop_front();
                    chk("bank_read", {8'(cyc - e.cyc), 8'(b), 12'h0, addr},
                                     {8'd1, 8'(e.bank), 12'h0, 4'(e.addr)});
                end
            end
        end
    endtask

    always @(negedge sys_clk) begin
        rd_t r;
        sw_t s;
        if (rst_n) begin
            mon_bank(0, bank0.en, bank0.we, bank0.addr, bank0.din);
            mon_bank(1, bank1.en, bank1.we, bank1.addr, bank1.din);
            if (rd_valid === 1'b1) begin
                chk("rd_expected", 32'(rdq.size() != 0), 32'd1);
                if (rdq.size() != 0) begin
                    r = rdq.pop_front();
                    chk("rd_data", {16'(cyc - r.cyc), 8'h0, rd_data}, {16'd2, 8'h0, 8'(r.data)});
                end
            end
            if (swap === 1'b1) begin
                chk("swap_expected", 32'(swq.size() != 0), 32'd1);
                if (swq.size() != 0) begin
                    s = swq.pop_front();
                    chk("swap_pulse", {8'(cyc - s.cyc), 8'h0, 7'h0, wr_bank, frame_cnt},
                                      {8'd1, 8'h0, 7'h0, 1'(s.wb), 8'(s.fc)});
                end
            end
        end
    end

    initial begin
        int n;
        model_reset();
        #3;
        do_reset();

        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 8'(i));

        cycle(1, 1, 0, 8'hAA);
        cycle(0, 0, 1, 8'h00);

        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 8'($urandom));
        cycle(0, 0, 0, 8'h00);

        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 0, 0, 8'($urandom));
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);

        n = 0;
        while (m_fc < 260 && n < 20000) begin
            cycle(($urandom % 8) != 0, ($urandom % 8) != 0, ($urandom % 16) == 0, 8'($urandom));
            n++;
        end
        chk("wrap_reached_in_budget", 32'(m_fc >= 260), 32'd1);

        repeat (3) cycle(0, 0, 0, 8'h00);
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 8'($urandom));
        do_reset();
        cycle(1, 0, 0, 8'h5C);
        repeat (3) cycle(0, 0, 0, 8'h00);

        chk("wq_drained",  32'(wq.size()),  32'd0);
        chk("raq_drained", 32'(raq.size()), 32'd0);
        chk("rdq_drained", 32'(rdq.size()), 32'd0);
        chk("swq_drained", 32'(swq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pingpong_bram_ctrl.md
# pingpong_bram_ctrl

Ping-pong controller for the two single-port 16×8 block RAMs (bank 0, bank 1) on the LED/debug path. Sequences writes from the pattern ROM into one bank while the other bank is read out. Swaps bank roles once a full frame has been written and the previous frame fully read. Replaces the free-running clock-gated bank switching with a single-clock, flag-reporting scheduler.

## Interface
Parameters:
- ADDR_W, 4, bank address width; DEPTH = 2**ADDR_W words per frame
- DATA_W, 8, word width

Ports:
- sys_clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- w_tick  in  1  one-cycle write request; consumes w_data
- w_data  in  DATA_W  word to write (ROM output)
- r_tick  in  1  one-cycle read request
- clr_flags  in  1  clears overrun/underrun
- bankN_en, bankN_we (N=0,1)  out  1  bank port enable / write enable
- bankN_addr  out  ADDR_W  bank address
- bankN_din  out  DATA_W  bank write data
- bankN_dout  in  DATA_W  bank read data (1-cycle registered BRAM)
- rd_data  out  DATA_W  read word, valid with rd_valid
- rd_valid  out  1  one-cycle strobe
- wr_bank  out  1  bank currently being written
- swap  out  1  one-cycle pulse on role swap
- frame_cnt  out  8  completed swaps, wraps 255→0
- overrun, underrun  out  1  sticky drop flags

## Operation
- States: FILL (first frame, no reads), RUN, SWAP (one cycle).
- Reset: state=FILL, wr_bank=0, wr_ptr=rd_ptr=0, all bank port outputs 0, rd_valid=0, swap=0, frame_cnt=0, flags=0.
- wr_ptr, rd_ptr are ADDR_W+1 bits; full = wr_ptr==DEPTH, done = rd_ptr==DEPTH.
- Write: w_tick in FILL/RUN with !full → bank[wr_bank] en=1, we=1, addr=wr_ptr[ADDR_W-1:0], din=w_data; wr_ptr++. If full → dropped, overrun=1.
- Read: r_tick in RUN with !done → bank[!wr_bank] en=1, we=0, addr=rd_ptr; rd_ptr++. If done, or in FILL → dropped, underrun=1.
- Both ticks in same cycle: both serviced (always opposite banks, no conflict).
- FILL→SWAP when full. RUN→SWAP when full && done. SWAP→RUN always.
- SWAP cycle: wr_bank toggles, wr_ptr=rd_ptr=0, swap=1, frame_cnt++. Ticks in SWAP are dropped and set the matching flag.
- Unused bank port: en=we=0, addr/din hold previous value.
- clr_flags clears both flags; a drop in the same cycle wins (flag stays 1).
- rst_n low mid-frame: immediate return to reset values; bank contents undefined to the controller, next frame starts with FILL.

## Timing
- All outputs registered except rd_data (mux of bankN_dout by a registered select).
- Tick sampled at edge N → bank port driven during cycle N+1 → BRAM output at edge N+2 → rd_valid=1 and rd_data valid during cycle N+2.
- Full/done evaluated from pointers after update; last write of frame at edge N → SWAP state at edge N+1 (if done), swap pulse during cycle N+1.
- Maximum throughput: one write and one read per cycle.

## Structure
- Package pingpong_pkg: state enum (FILL, RUN, SWAP), ADDR_W/DATA_W defaults, DEPTH constant.
- One sub-module, pp_bank_port: per-bank registered mux selecting write or read access by role; instantiated twice.
- Top block holds FSM, pointers, flags, frame counter, read-valid pipeline.

## Test plan
- Reset, 16 w_tick with data 0x00..0x0F, no r_tick → bank0 written addr 0..15, swap pulse after last write, wr_bank=1, frame_cnt=1.
- r_tick during FILL → no bank access, rd_valid stays 0, underrun=1; clr_flags → 0.
- After first swap, 16 simultaneous w_tick/r_tick → bank1 written, rd_data 0x00..0x0F each 2 cycles after its r_tick, then swap, wr_bank=0, frame_cnt=2.
- 17th w_tick while reader not done → no bank write, overrun=1, no swap until 16 reads complete.
- Tick in the SWAP cycle → dropped, flag set; 256 frames → frame_cnt wraps to 0.
- rst_n asserted mid-frame (wr_ptr=7) → all outputs to reset values asynchronously, next write goes to bank0 addr 0.
